prach_mixer: RTL and testbench



---
 rtl/prach_mixer.sv | 178 +++++++++++++++++
 tb/tb_prach_mixer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/prach_mixer.sv
// PRACH complex mixer: aligns the IQ stream with the NCO cos/sin stream,
// monitors that alignment, then multiplies, rounds half-up and saturates.
module prach_mixer #(
  parameter int unsigned NCO_LATENCY = 4,
  parameter bit          CONJ        = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din_i,
  input  logic [15:0] din_q,
  input  logic        din_dv,
  input  logic [7:0]  din_chn,
  input  logic        sync_in,
  input  logic [15:0] nco_cos,
  input  logic [15:0] nco_sin,
  input  logic        nco_dv,
  input  logic [7:0]  nco_chn,
  input  logic        nco_sync,
  output logic [15:0] dout_i,
  output logic [15:0] dout_q,
  output logic        dout_dv,
  output logic [7:0]  dout_chn,
  output logic        sync_out,
  output logic        err_align
);

  localparam int unsigned LAST = NCO_LATENCY - 1;

  logic signed [15:0]     ai_q   [NCO_LATENCY];
  logic signed [15:0]     aq_q   [NCO_LATENCY];
  logic [7:0]             achn_q [NCO_LATENCY];
  logic [NCO_LATENCY-1:0] adv_q;
  logic [NCO_LATENCY-1:0] async_q;

  logic signed [15:0] a_i, a_q, cos_s, sin_s;
  logic [7:0]         a_chn;
  logic               a_dv, a_sync;
  logic               mismatch, err_q, err_d;
  logic               unused_nco_chn;

  logic signed [31:0] pii_d, pqs_d, pqc_d, pis_d;
  logic signed [31:0] m1_pii_q, m1_pqs_q, m1_pqc_q, m1_pis_q;
  logic               m1_dv_q, m1_sync_q;
  logic [7:0]         m1_chn_q;

  logic signed [32:0] re_d, im_d;
  logic signed [32:0] m2_re_q, m2_im_q;
  logic               m2_dv_q, m2_sync_q;
  logic [7:0]         m2_chn_q;

  logic [15:0] dout_i_q, dout_q_q;
  logic [7:0]  dout_chn_q;
  logic        dout_dv_q, sync_out_q;

  assign a_i    = ai_q[LAST];
  assign a_q    = aq_q[LAST];
  assign a_chn  = achn_q[LAST];
  assign a_dv   = adv_q[LAST];
  assign a_sync = async_q[LAST];
  assign cos_s  = nco_cos;
  assign sin_s  = nco_sin;

  // Only the low three channel bits take part in the alignment check.
  assign unused_nco_chn = ^nco_chn[7:3];

  assign mismatch = (a_dv != nco_dv) | (a_sync != nco_sync) |
                    (a_dv & (a_chn[2:0] != nco_chn[2:0]));

  // A fresh mismatch overrides a clean sync in the same cycle.
  always_comb begin
    err_d = err_q;
    if (mismatch) begin
      err_d = 1'b1;
    end else if (a_sync) begin
      err_d = 1'b0;
    end
  end

  always_comb begin
    pii_d = 32'(a_i) * 32'(cos_s);
    pqs_d = 32'(a_q) * 32'(sin_s);
    pqc_d = 32'(a_q) * 32'(cos_s);
    pis_d = 32'(a_i) * 32'(sin_s);
  end

  always_comb begin
    if (CONJ) begin
      re_d = 33'(m1_pii_q) + 33'(m1_pqs_q);
      im_d = 33'(m1_pqc_q) - 33'(m1_pis_q);
    end else begin
      re_d = 33'(m1_pii_q) - 33'(m1_pqs_q);
      im_d = 33'(m1_pqc_q) + 33'(m1_pis_q);
    end
  end

  function automatic logic [15:0] round_sat(input logic signed [32:0] x);
    logic signed [33:0] t;
    t = ($signed({x[32], x}) + 34'sd8192) >>> 14;
    if (t > 34'sd32767) begin
      round_sat = 16'h7fff;
    end else if (t < -34'sd32768) begin
      round_sat = 16'h8000;
    end else begin
      round_sat = t[15:0];
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NCO_LATENCY; k++) begin
        ai_q[k]   <= '0;
        aq_q[k]   <= '0;
        achn_q[k] <= '0;
      end
      adv_q      <= '0;
      async_q    <= '0;
      err_q      <= 1'b0;
      m1_pii_q   <= '0;
      m1_pqs_q   <= '0;
      m1_pqc_q   <= '0;
      m1_pis_q   <= '0;
      m1_dv_q    <= 1'b0;
      m1_sync_q  <= 1'b0;
      m1_chn_q   <= '0;
      m2_re_q    <= '0;
      m2_im_q    <= '0;
      m2_dv_q    <= 1'b0;
      m2_sync_q  <= 1'b0;
      m2_chn_q   <= '0;
      dout_i_q   <= '0;
      dout_q_q   <= '0;
      dout_dv_q  <= 1'b0;
      dout_chn_q <= '0;
      sync_out_q <= 1'b0;
    end else begin
      ai_q[0]    <= din_i;
      aq_q[0]    <= din_q;
      achn_q[0]  <= din_chn;
      adv_q[0]   <= din_dv;
      async_q[0] <= sync_in;
      for (int unsigned k = 1; k < NCO_LATENCY; k++) begin
        ai_q[k]    <= ai_q[k-1];
        aq_q[k]    <= aq_q[k-1];
        achn_q[k]  <= achn_q[k-1];
        adv_q[k]   <= adv_q[k-1];
        async_q[k] <= async_q[k-1];
      end
      err_q      <= err_d;
      m1_pii_q   <= pii_d;
      m1_pqs_q   <= pqs_d;
      m1_pqc_q   <= pqc_d;
      m1_pis_q   <= pis_d;
      m1_dv_q    <= a_dv;
      m1_sync_q  <= a_sync;
      m1_chn_q   <= a_chn;
      m2_re_q    <= re_d;
      m2_im_q    <= im_d;
      m2_dv_q    <= m1_dv_q;
      m2_sync_q  <= m1_sync_q;
      m2_chn_q   <= m1_chn_q;
      if (m2_dv_q) begin
        dout_i_q <= round_sat(m2_re_q);
        dout_q_q <= round_sat(m2_im_q);
      end
      dout_dv_q  <= m2_dv_q;
      dout_chn_q <= m2_chn_q;
      sync_out_q <= m2_sync_q;
    end
  end

  assign dout_i    = dout_i_q;
  assign dout_q    = dout_q_q;
  assign dout_dv   = dout_dv_q;
  assign dout_chn  = dout_chn_q;
  assign sync_out  = sync_out_q;
  assign err_align = err_q;

endmodule

// File: tb/tb_prach_mixer.sv
// Bench for prach_mixer: one CONJ=1 and one CONJ=0 instance share a scripted
// stimulus; the bench plays the NCO and predicts every output cycle.
module tb_prach_mixer;

  localparam int N = 960;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din_i, din_q, nco_cos, nco_sin;
  logic        din_dv, sync_in, nco_dv, nco_sync;
  logic [7:0]  din_chn, nco_chn;

  logic [15:0] d0_i, d0_q, d1_i, d1_q;
  logic        d0_dv, d0_sync, d0_err, d1_dv, d1_sync, d1_err;
  logic [7:0]  d0_chn, d1_chn;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  longint s_rst [N], s_i [N], s_q [N], s_dv [N], s_chn [N], s_sync [N], s_c [N], s_s [N];
  longint n_dv_a [N], n_chn_a [N], n_sync_a [N], n_c_a [N], n_s_a [N];
  longint ch_c [8], ch_s [8];

  prach_mixer #(.NCO_LATENCY(4), .CONJ(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .din_i(din_i), .din_q(din_q), .din_dv(din_dv),
    .din_chn(din_chn), .sync_in(sync_in), .nco_cos(nco_cos), .nco_sin(nco_sin),
    .nco_dv(nco_dv), .nco_chn(nco_chn), .nco_sync(nco_sync),
    .dout_i(d0_i), .dout_q(d0_q), .dout_dv(d0_dv), .dout_chn(d0_chn),
    .sync_out(d0_sync), .err_align(d0_err)
  );

  prach_mixer #(.NCO_LATENCY(4), .CONJ(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .din_i(din_i), .din_q(din_q), .din_dv(din_dv),
    .din_chn(din_chn), .sync_in(sync_in), .nco_cos(nco_cos), .nco_sin(nco_sin),
    .nco_dv(nco_dv), .nco_chn(nco_chn), .nco_sync(nco_sync),
    .dout_i(d1_i), .dout_q(d1_q), .dout_dv(d1_dv), .dout_chn(d1_chn),
    .sync_out(d1_sync), .err_align(d1_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic longint rnd16();
    return longint'($urandom_range(0, 65535)) - 64'sd32768;
  endfunction

  // True when cycles a..b all exist and carry no reset.
  function automatic bit ok(input int a, input int b);
    if (a < 0) return 1'b0;
    for (int t = a; t <= b; t++) if (s_rst[t] != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Complex product rounded half-up to Q15 and saturated to 16 bits.
  function automatic longint mix(input bit conj, input bit want_re,
                                 input longint i, input longint q,
                                 input longint c, input longint s);
    longint v;
    if (want_re) v = conj ? (i * c + q * s) : (i * c - q * s);
    else         v = conj ? (q * c - i * s) : (q * c + i * s);
    v = (v + 8192) >>> 14;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  task automatic put(input int k, input longint i, input longint q, input longint chn,
                     input longint sync, input longint c, input longint s);
    s_i[k] = i; s_q[k] = q; s_dv[k] = 1; s_chn[k] = chn;
    s_sync[k] = sync; s_c[k] = c; s_s[k] = s;
  endtask

  initial begin
    longint a_dv, a_chn, a_sync, x_dv, x_chn, x_sync, err_m;
    longint e0_i, e0_q, e1_i, e1_q;
    bit     mism;
    int     src;

    for (int k = 0; k < N; k++) begin
      s_rst[k] = (k < 3) ? 1 : 0;
      s_i[k] = rnd16(); s_q[k] = rnd16(); s_dv[k] = 0;
      s_chn[k] = longint'($urandom_range(0, 255)); s_sync[k] = 0;
      s_c[k] = rnd16(); s_s[k] = rnd16();
    end

    put(10, 1000, -2000, 3, 0, 16384, 0);
    put(11, 1000, -2000, 5, 0, 0, 16384);
    put(12, 32767, 32767, 1, 0, 16384, 16384);
    put(13, 1, 0, 2, 0, 8192, 0);
    put(14, -1, 0, 2, 0, 8192, 0);
    put(15, -32768, 32767, 7, 0, 16384, -16384);
    put(30, rnd16(), rnd16(), 4, 0, rnd16(), rnd16());
    for (int j = 0; j < 21; j++) put(40 + j, rnd16(), rnd16(), j % 8, 0, rnd16(), rnd16());
    put(70, rnd16(), rnd16(), 0, 1, rnd16(), rnd16());

    for (int j = 0; j < 8; j++) begin
      ch_c[j] = rnd16();
      ch_s[j] = rnd16();
    end
    for (int j = 0; j < 800; j++)
      put(100 + j, rnd16(), rnd16(), j % 8, (j % 8 == 0) ? 1 : 0, ch_c[j % 8], ch_s[j % 8]);

    for (int j = 0; j < 10; j++)
      put(920 + j, rnd16(), rnd16(), longint'($urandom_range(0, 255)),
          (j == 1) ? 1 : 0, rnd16(), rnd16());
    s_rst[926] = 1;

    // Ideal NCO: its output is the input stream delayed by four cycles.
    for (int k = 0; k < N; k++) begin
      if (ok(k - 4, k - 1)) begin
        n_dv_a[k] = s_dv[k-4]; n_chn_a[k] = s_chn[k-4]; n_sync_a[k] = s_sync[k-4];
        n_c_a[k] = s_c[k-4];   n_s_a[k] = s_s[k-4];
      end else begin
        n_dv_a[k] = 0; n_chn_a[k] = 0; n_sync_a[k] = 0;
        n_c_a[k] = rnd16(); n_s_a[k] = rnd16();
      end
    end
    n_chn_a[34] = 5;

    err_m = 0; e0_i = 0; e0_q = 0; e1_i = 0; e1_q = 0;
    for (int k = 0; k < N; k++) begin
      rst = s_rst[k][0];
      din_i = s_i[k][15:0]; din_q = s_q[k][15:0]; din_dv = s_dv[k][0];
      din_chn = s_chn[k][7:0]; sync_in = s_sync[k][0];
      nco_cos = n_c_a[k][15:0]; nco_sin = n_s_a[k][15:0]; nco_dv = n_dv_a[k][0];
      nco_chn = n_chn_a[k][7:0]; nco_sync = n_sync_a[k][0];
      @(posedge clk);
      #1;
      cyc = k;

      if (s_rst[k] != 0) begin
        err_m = 0; e0_i = 0; e0_q = 0; e1_i = 0; e1_q = 0;
        x_dv = 0; x_chn = 0; x_sync = 0;
      end else begin
        if (ok(k - 4, k - 1)) begin
          a_dv = s_dv[k-4]; a_chn = s_chn[k-4]; a_sync = s_sync[k-4];
        end else begin
          a_dv = 0; a_chn = 0; a_sync = 0;
        end
        mism = (a_dv != n_dv_a[k]) || (a_sync != n_sync_a[k]) ||
               ((a_dv != 0) && ((a_chn % 8) != (n_chn_a[k] % 8)));
        if (mism) err_m = 1;
        else if (a_sync != 0) err_m = 0;

        src = k - 6;
        if (ok(src, k)) begin
          x_dv = s_dv[src]; x_chn = s_chn[src]; x_sync = s_sync[src];
        end else begin
          x_dv = 0; x_chn = 0; x_sync = 0;
        end
        if (x_dv != 0) begin
          e0_i = mix(1'b1, 1'b1, s_i[src], s_q[src], n_c_a[src+4], n_s_a[src+4]);
          e0_q = mix(1'b1, 1'b0, s_i[src], s_q[src], n_c_a[src+4], n_s_a[src+4]);
          e1_i = mix(1'b0, 1'b1, s_i[src], s_q[src], n_c_a[src+4], n_s_a[src+4]);
          e1_q = mix(1'b0, 1'b0, s_i[src], s_q[src], n_c_a[src+4], n_s_a[src+4]);
        end
      end

      check("dv0", longint'(d0_dv), x_dv);
      check("chn0", longint'(d0_chn), x_chn);
      check("sync0", longint'(d0_sync), x_sync);
      check("err0", longint'(d0_err), err_m);
      check("i0", longint'($signed(d0_i)), e0_i);
      check("q0", longint'($signed(d0_q)), e0_q);
      check("dv1", longint'(d1_dv), x_dv);
      check("chn1", longint'(d1_chn), x_chn);
      check("sync1", longint'(d1_sync), x_sync);
      check("err1", longint'(d1_err), err_m);
      check("i1", longint'($signed(d1_i)), e1_i);
      check("q1", longint'($signed(d1_q)), e1_q);

      case (k)
        15: check("ident_dv_early", longint'(d0_dv), 0);
        16: begin
          check("ident_i", longint'($signed(d0_i)), 1000);
          check("ident_q", longint'($signed(d0_q)), -2000);
          check("ident_chn", longint'(d0_chn), 3);
          check("ident_dv", longint'(d0_dv), 1);
          check("ident_err", longint'(d0_err), 0);
          check("ident_i_c0", longint'($signed(d1_i)), 1000);
          check("ident_q_c0", longint'($signed(d1_q)), -2000);
        end
        17: begin
          check("quarter_i", longint'($signed(d0_i)), -2000);
          check("quarter_q", longint'($signed(d0_q)), -1000);
          check("quarter_i_c0", longint'($signed(d1_i)), 2000);
          check("quarter_q_c0", longint'($signed(d1_q)), 1000);
        end
        18: begin
          check("sat_i", longint'($signed(d0_i)), 32767);
          check("sat_q", longint'($signed(d0_q)), 0);
          check("sat_q_c0", longint'($signed(d1_q)), 32767);
        end
        19: check("round_up", longint'($signed(d0_i)), 1);
        20: check("round_neg", longint'($signed(d0_i)), 0);
        21: begin
          check("sat_neg_i", longint'($signed(d0_i)), -32768);
          check("sat_neg_q", longint'($signed(d0_q)), -1);
        end
        33: check("err_before", longint'(d0_err), 0);
        34: check("err_set", longint'(d0_err), 1);
        54: check("err_sticky", longint'(d0_err), 1);
        73: check("err_hold", longint'(d0_err), 1);
        74: check("err_clear", longint'(d0_err), 0);
        926: begin
          check("rst_dv", longint'(d0_dv), 0);
          check("rst_i", longint'(d0_i), 0);
          check("rst_q", longint'(d0_q), 0);
          check("rst_chn", longint'(d0_chn), 0);
        end
        933: check("post_rst_dv", longint'(d0_dv), 1);
        default: ;
      endcase
      if (k >= 927 && k <= 932) check("rst_drop_dv", longint'(d0_dv), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
